// File: rtl/arb_pkg.sv
// Shared widths and channel indices for the arbiter ingress queues.
package arb_pkg;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;
  localparam int CH_D   = 3;
endpackage

// File: rtl/arb_ingress_queues_if.sv
// Producer/arbiter-facing bundle of the ingress queues.
interface arb_ingress_queues_if
  import arb_pkg::*;
  ();
  logic [NUM_CH-1:0] in_valid;
  logic [DATA_W-1:0] in_data_a;
  logic [DATA_W-1:0] in_data_b;
  logic [DATA_W-1:0] in_data_c;
  logic [DATA_W-1:0] in_data_d;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH-1:0] req;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [DATA_W-1:0] head_c;
  logic [DATA_W-1:0] head_d;
  logic [NUM_CH-1:0] grant;
  logic [CNT_W-1:0]  count_a;
  logic [CNT_W-1:0]  count_b;
  logic [CNT_W-1:0]  count_c;
  logic [CNT_W-1:0]  count_d;
  logic [1:0]        err;

  modport master (
    output in_valid, in_data_a, in_data_b,
    output in_data_c, in_data_d, grant,
    input  in_ready, req, head_a, head_b,
    input  head_c, head_d, count_a, count_b,
    input  count_c, count_d, err
  );

  modport slave (
    input  in_valid, in_data_a, in_data_b,
    input  in_data_c, in_data_d, grant,
    output in_ready, req, head_a, head_b,
    output head_c, head_d, count_a, count_b,
    output count_c, count_d, err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; count is the full/empty authority.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      din,
  input  logic                   pop,
  output logic [DATA_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr;
  logic              rd;

  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  // Stale entries stay hidden so an empty queue reads as zero.
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/arb_ingress_queues.sv
// Per-channel ingress FIFOs feeding the round-robin arbiter.
module arb_ingress_queues
  import arb_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  arb_ingress_queues_if.slave bus
);
  logic [DATA_W-1:0] din  [NUM_CH];
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              multi;
  logic              onehot;
  logic              bad_empty;

  assign din[CH_A] = bus.in_data_a;
  assign din[CH_B] = bus.in_data_b;
  assign din[CH_C] = bus.in_data_c;
  assign din[CH_D] = bus.in_data_d;

  assign bus.in_ready = ~full & {NUM_CH{~rst}};
  assign bus.req      = ~empty;
  assign push         = bus.in_valid & bus.in_ready;

  assign multi     = (bus.grant & (bus.grant - 4'd1)) != '0;
  assign onehot    = (bus.grant != '0) & ~multi;
  assign bad_empty = |(bus.grant & empty);
  assign pop       = bus.grant & ~empty & {NUM_CH{onehot}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .dout  (head[i]),
      .count (cnt[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign bus.head_a  = head[CH_A];
  assign bus.head_b  = head[CH_B];
  assign bus.head_c  = head[CH_C];
  assign bus.head_d  = head[CH_D];
  assign bus.count_a = cnt[CH_A];
  assign bus.count_b = cnt[CH_B];
  assign bus.count_c = cnt[CH_C];
  assign bus.count_d = cnt[CH_D];

  // Error flags are sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err <= '0;
    end else begin
      bus.err[0] <= bus.err[0] | bad_empty;
      bus.err[1] <= bus.err[1] | multi;
    end
  end
endmodule

// File: doc/arb_ingress_queues.md
Name: arb_ingress_queues

Overview:
Upstream stage of the 4-port round-robin arbiter pipeline. It holds one small FIFO per channel (a, b, c, d) and presents each FIFO head word plus a request vector to the arbiter. It consumes the arbiter's one-hot grant to pop the granted channel. It decouples bursty producers from the arbiter's one-word-per-cycle service.

Parameters:
DATA_W, 8, width of each channel data word
DEPTH, 4, entries per channel FIFO; power of two, >= 2
(NUM_CH fixed at 4, matching the arbiter's a/b/c/d ports)

Ports:
clk  input  1  single rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  4  per-channel push request; bit0=a, bit1=b, bit2=c, bit3=d
in_data_a  input  DATA_W  channel a push data
in_data_b  input  DATA_W  channel b push data
in_data_c  input  DATA_W  channel c push data
in_data_d  input  DATA_W  channel d push data
in_ready  output  4  per-channel FIFO not full
req  output  4  per-channel FIFO non-empty; drives the arbiter request inputs
head_a  output  DATA_W  channel a FIFO head word
head_b  output  DATA_W  channel b FIFO head word
head_c  output  DATA_W  channel c FIFO head word
head_d  output  DATA_W  channel d FIFO head word
grant  input  4  one-hot grant from the arbiter; pops that channel this cycle
count_a..count_d  output  $clog2(DEPTH)+1 each  occupancy per channel
err  output  2  sticky error flags; bit0 = grant to an empty channel, bit1 = grant not one-hot

Behaviour:
- Reset (async, rst=1): all pointers and counts go to 0. req=0, head_*=0, count_*=0, err=0. in_ready forced to 0 while rst is high; it goes to 1 on the first cycle after release.
- Push: on a clk edge with in_valid[i] & in_ready[i], write in_data_i at wr_ptr[i]; wr_ptr[i] increments modulo DEPTH.
- in_ready[i] = !full[i], where full means count==DEPTH. It is combinational from the registered count; no dependency on the same-cycle grant.
- in_valid[i] while in_ready[i]=0: the word is ignored and not stored. This is not an error; the producer must hold the word.
- Pop: on a clk edge with grant[i] & req[i] and grant one-hot, rd_ptr[i] increments modulo DEPTH.
- req[i] = (count[i] != 0). head_i = mem[i][rd_ptr[i]]. Both are registered-state derived and valid in the same cycle as req.
- Latency: a word pushed at edge N is visible on head_i/req[i] after edge N; there is no same-cycle bypass. Minimum push-to-grant is 1 cycle.
- Simultaneous push and pop on one channel: both occur and the count is unchanged. On an empty channel, pop is illegal (see err). On a full channel, push is blocked by in_ready.
- Pointer wrap: pointers have width log2(DEPTH) and wrap naturally. count is the full/empty authority.
- Grant to empty channel (grant[i] & !req[i]): no pop, err[0] sets.
- Grant with more than one bit set: no pop on any channel, err[1] sets.
- grant=0: no pop.
- err bits clear only on rst.
- Channels are fully independent apart from the shared err flags.
- Reset mid-operation: all contents are discarded immediately (async). The first post-reset push lands in entry 0.

Decomposition:
- Shared package arb_pkg: DATA_W, NUM_CH=4, DEPTH, PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1, channel index constants CH_A..CH_D.
- Sub-module sync_fifo (parameters DATA_W, DEPTH; ports clk, rst, push, din, pop, dout, count, full, empty), instantiated 4 times.
- The top level holds the handshake logic, the one-hot check, and the err registers.

Test Plan:
1. Reset release, then push a=10, b=26, c=14, d=9 in one cycle with grant=0 -> next cycle req=4'b1111, head_a=10, head_b=26, head_c=14, head_d=9, counts=1.
2. Grants 0001,0010,0100,1000 on consecutive cycles after scenario 1 -> req clears one bit per cycle to 0000; err=0.
3. Push 5 words 1,2,3,4,5 into channel a with DEPTH=4 and no grant -> in_ready[0]=0 after 4th push, count_a=4, word 5 not stored. Four grants 0001 then yield head_a 1,2,3,4 in order.
4. Channel c holding 1 word, push 7 and grant 0100 in the same cycle -> count_c stays 1, head_c=7 next cycle. Then 6 more push/pop pairs verify wrap with FIFO order intact.
5. grant=0010 with channel b empty -> no state change, err=2'b01. Then grant=0011 with a and b non-empty -> no pop, err=2'b11.
6. Assert rst asynchronously between edges with all FIFOs partly full -> req, head_*, count_* and err go to 0 without a clock edge. A post-release push of 26 on b gives head_b=26.
